// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  // Access sequencer states: IDLE accepts requests, BUSY counts down wait states
  typedef enum logic {IDLE, BUSY} stateT;

  // Width of the wait-state down-counter (supports up to 15 extra cycles)
  localparam int CNT_W = 4;

  // Byte lanes per 32-bit word
  localparam int BYTES = 4;

  // Counter value loaded on accept so that BUSY lasts exactly `waits` cycles
  function automatic logic [CNT_W-1:0] cntLoad(input int waits);
    return (waits > 0) ? CNT_W'(waits - 1) : '0;
  endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Word-organised synchronous RAM with byte-lane write enables and read-first output register.
// Latency: read data registered, visible the cycle after the access edge.
// Backpressure: none; performs an access on every edge where acc is high.
module dmem_ram_be
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic              zero,
  input  logic [BYTES-1:0]  wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Lane-masked write; a zeroed (rejected) access never touches the array
  always_ff @(posedge clk) begin
    if (acc && !zero) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read-first output register: captures the word as it was before this edge's write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (acc) begin
      rdata <= zero ? '0 : mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's SRAM-like data port, with optional wait states.
// Latency: read data one cycle after completion; completion WAIT_CYCLES cycles after request.
// Backpressure: mem_stall high while an access is pending; optional DMEM_RANGE_ERR_EN adds range checking.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam bit              SINGLE   = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = cntLoad(WAIT_CYCLES);

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      latAddr;
  logic [31:0]      latWdata;
  logic [BYTES-1:0] latWen;

  logic             accept;
  logic             lastBusy;
  logic             fire;
  logic [31:0]      accAddr;
  logic [31:0]      accWdata;
  logic [BYTES-1:0] accWen;
  logic             outRange;

  // Select the live request in IDLE or the latched one in BUSY, and decide when it completes
  always_comb begin
    accept   = rst && (state == IDLE) && mem_en;
    lastBusy = rst && (state == BUSY) && (cnt == '0);
    fire     = (accept && SINGLE) || lastBusy;
    accAddr  = mem_addr;
    accWdata = mem_wdata;
    accWen   = mem_wen;
    if (state == BUSY) begin
      accAddr  = latAddr;
      accWdata = latWdata;
      accWen   = latWen;
    end
    // Stall covers the accept cycle plus every BUSY cycle except the completing one
    mem_stall = (accept && !SINGLE) || (rst && (state == BUSY) && (cnt != '0));
  end

  // Wait-state sequencer: latch the request on accept, count down, complete at cnt==0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      latAddr  <= '0;
      latWdata <= '0;
      latWen   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_en && !SINGLE) begin
            latAddr  <= mem_addr;
            latWdata <= mem_wdata;
            latWen   <= mem_wen;
            cnt      <= CNT_LOAD;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_RANGE_ERR_EN
  logic unusedLow;
  assign unusedLow = ^accAddr[1:0];
  assign outRange  = |accAddr[31:ADDR_W+2];

  // One-cycle error pulse aligned with the zeroed read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_err <= 1'b0;
    else      mem_err <= fire && outRange;
  end
`else
  // Upper address bits alias onto the array; no error reporting
  logic unusedBits;
  assign unusedBits = ^{accAddr[1:0], accAddr[31:ADDR_W+2]};
  assign outRange   = 1'b0;
  assign mem_err    = 1'b0;
`endif

  dmem_ram_be #(
    .ADDR_W(ADDR_W)
  ) uRam (
    .clk   (clk),
    .rst   (rst),
    .acc   (fire),
    .zero  (outRange),
    .wen   (accWen),
    .addr  (accAddr[ADDR_W+1:2]),
    .wdata (accWdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: single-cycle and 3-wait-state instances.
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: stall windows checked cycle by cycle on the wait-state instance.
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  logic        en0, en3;
  logic [3:0]  wen0, wen3;
  logic [31:0] addr0, addr3, wdata0, wdata3;
  logic [31:0] rdata0, rdata3;
  logic        stall0, stall3, err0, err3;

  int passCnt;
  int totalCnt;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_en(en0), .mem_wen(wen0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_stall(stall0), .mem_err(err0)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .mem_en(en3), .mem_wen(wen3), .mem_addr(addr3),
    .mem_wdata(wdata3), .mem_rdata(rdata3), .mem_stall(stall3), .mem_err(err3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the wait-state instance: accept cycle plus three BUSY cycles
  task automatic acc3(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    en3 = 1'b1; addr3 = a; wen3 = w; wdata3 = d;
    tick();
    en3 = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0;
    en0 = 1'b0; wen0 = 4'h0; addr0 = '0; wdata0 = '0;
    en3 = 1'b0; wen3 = 4'h0; addr3 = '0; wdata3 = '0;
    passCnt = 0; totalCnt = 0;

    #12;
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_stall0", {31'b0, stall0}, 32'h0);
    check("rst_err0",   {31'b0, err0},   32'h0);
    check("rst_rdata3", rdata3, 32'h0);
    check("rst_stall3", {31'b0, stall3}, 32'h0);
    check("rst_err3",   {31'b0, err3},   32'h0);
    tick();
    rst = 1'b1;

    // ---- single-cycle instance ----
    en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    #1 check("nostall_w", {31'b0, stall0}, 32'h0);
    tick();
    wen0 = 4'h0;
    #1 check("nostall_r", {31'b0, stall0}, 32'h0);
    tick();
    check("wr_rd_10", rdata0, 32'hDEADBEEF);

    wen0 = 4'hF; addr0 = 32'h20; wdata0 = 32'h11223344;
    tick();
    wen0 = 4'h4; wdata0 = 32'h00AA0000;
    tick();
    check("read_first", rdata0, 32'h11223344);
    wen0 = 4'h0;
    tick();
    check("byte_lane", rdata0, 32'h11AA3344);

    en0 = 1'b0; wen0 = 4'hF; wdata0 = 32'h0;
    tick();
    check("hold_rdata", rdata0, 32'h11AA3344);
    en0 = 1'b1; wen0 = 4'h0;
    tick();
    check("no_wr_wo_en", rdata0, 32'h11AA3344);

    wen0 = 4'hF; addr0 = 32'h0; wdata0 = 32'hA0A0A0A0;
    tick();
    addr0 = 32'h4; wdata0 = 32'hB1B1B1B1;
    tick();
    addr0 = 32'h8; wdata0 = 32'hC2C2C2C2;
    tick();
    wen0 = 4'h0; addr0 = 32'h0;
    tick();
    check("b2b_0", rdata0, 32'hA0A0A0A0);
    addr0 = 32'h4;
    tick();
    check("b2b_4", rdata0, 32'hB1B1B1B1);
    addr0 = 32'h8;
    tick();
    check("b2b_8", rdata0, 32'hC2C2C2C2);

    wen0 = 4'hF; addr0 = 32'h0000_1000; wdata0 = 32'h55555555;
    tick();
    en0 = 1'b0; wen0 = 4'h0; addr0 = 32'h0;
`ifdef DMEM_RANGE_ERR_EN
    check("range_rdata", rdata0, 32'h0);
    check("range_err",   {31'b0, err0}, 32'h1);
    tick();
    check("range_err_end", {31'b0, err0}, 32'h0);
    en0 = 1'b1;
    tick();
    check("range_nowrite", rdata0, 32'hA0A0A0A0);
`else
    check("alias_rdata", rdata0, 32'hA0A0A0A0);
    check("alias_err",   {31'b0, err0}, 32'h0);
    tick();
    check("alias_err_hold", {31'b0, err0}, 32'h0);
    en0 = 1'b1;
    tick();
    check("alias_write", rdata0, 32'h55555555);
`endif
    en0 = 1'b0;

    // ---- three-wait-state instance ----
    acc3(32'h10, 4'hF, 32'h12345678);
    acc3(32'h30, 4'hF, 32'h0BADF00D);
    acc3(32'h40, 4'hF, 32'hCAFEF00D);

    en3 = 1'b1; wen3 = 4'h0; addr3 = 32'h10;
    #1 check("stall_c0", {31'b0, stall3}, 32'h1);
    tick();
    addr3 = 32'h30;
    check("stall_c1", {31'b0, stall3}, 32'h1);
    tick();
    check("stall_c2", {31'b0, stall3}, 32'h1);
    tick();
    en3 = 1'b0;
    #1 check("stall_c3", {31'b0, stall3}, 32'h0);
    tick();
    check("ws_rdata", rdata3, 32'h12345678);
    check("ws_idle_stall", {31'b0, stall3}, 32'h0);

    en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h40; wdata3 = 32'hFFFFFFFF;
    tick();
    en3 = 1'b0;
    tick();
    check("busy_pre_rst", {31'b0, stall3}, 32'h1);
    rst = 1'b0;
    #1;
    check("rst_mid_stall", {31'b0, stall3}, 32'h0);
    check("rst_mid_rdata", rdata3, 32'h0);
    check("rst_rdata0_b",  rdata0, 32'h0);
    tick();
    rst = 1'b1;
    acc3(32'h40, 4'h0, 32'h0);
    check("abandon_wr", rdata3, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
